math_computer_pipe: RTL
=======================

Name: math_computer_pipe

Overview:
- Parametrised, pipelined successor of the team's 3-operand adder.
- Accepts NB_OPERANDS unsigned operands plus a per-transaction mode over a ready/valid input and computes a sum, saturated sum, maximum or minimum.
- Results are queued in an internal output FIFO, so the block sustains one transaction per cycle and tolerates downstream back-pressure.
- Sits between a stimulus/producer stage and any ready/valid consumer.

Parameters:
- DATASIZE, 8, width in bits of each operand.
- NB_OPERANDS, 3, number of operands per transaction; legal values are 2 or more.
- FIFO_DEPTH, 4, number of result entries in the output FIFO; legal values are 2 or more, and non-powers-of-2 are supported.
- RESSIZE (localparam), DATASIZE+$clog2(NB_OPERANDS), result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction.
- in_mode  in  2  operation select: 00 sum, 01 max, 10 min, 11 saturating sum.
- in_operands  in  NB_OPERANDS*DATASIZE  operand i is at bits [i*DATASIZE +: DATASIZE].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  RESSIZE  result.
- out_sat  out  1  result was clipped (mode 11 only).
- occupancy  out  $clog2(FIFO_DEPTH+2)  number of in-flight transactions plus stored entries.

Behaviour:
- Reset (async; outputs forced immediately on rst rising):
  - out_valid=0, out_result=0, out_sat=0, occupancy=0, in_ready=0 while rst is high.
  - Stage register and FIFO are emptied; pointers go to 0.
  - Contents in flight or queued when rst rises are discarded; there is no partial output.
- Handshake:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - A producer must hold in_valid and its data until accepted.
  - out_result and out_sat stay stable while out_valid=1 and out_ready=0.
  - out_valid does not depend combinationally on out_ready.
- Pipeline:
  - S1 is a register stage capturing operands and mode at input acceptance (edge k).
  - At edge k+1 the S1 result is computed and written into the FIFO.
  - out_valid = FIFO not empty. With an empty FIFO, the result is visible after edge k+1: latency is 2 edges, 1 cycle after acceptance.
- Flow control:
  - occupancy = S1_valid + FIFO_count.
  - in_ready = !rst && occupancy < FIFO_DEPTH, combinational from registers only. A transaction in S1 therefore always has a FIFO slot, and S1 never stalls.
  - Simultaneous accept and pop: occupancy is unchanged.
  - Throughput is 1 transaction/cycle when out_ready stays high.
- FIFO:
  - Circular buffer; read and write pointers wrap from FIFO_DEPTH-1 to 0.
  - Write when full and read when empty cannot occur by construction. Implementation asserts this as a property.
  - Order is strictly preserved.
- Arithmetic (unsigned, operands zero-extended to RESSIZE):
  - 00: sum of all operands, full precision, never wraps.
  - 01 / 10: maximum / minimum operand, zero-extended. Ties return that value.
  - 11: sum clipped to 2^DATASIZE-1. out_sat=1 if the true sum exceeds it, else 0.
  - out_sat=0 for modes 00, 01 and 10.
- occupancy output is registered and updated each edge.

Test Plan:
All scenarios use DATASIZE=8, NB_OPERANDS=3, FIFO_DEPTH=4.

1. Mode 00, operands 255,255,255, out_ready=1 -> out_result=765 (0x2FD), out_sat=0, out_valid high one cycle after acceptance, then low.
2. Mode 11, operands 255,255,255, then 10,20,30 -> results 255 with out_sat=1, then 60 with out_sat=0.
3. Mode 01, then mode 10, operands 7,200,13 -> results 200 then 7; out_sat=0 for both.
4. out_ready=0, in_valid held high with sums 1..6 -> exactly 4 accepted and in_ready drops after the 4th; occupancy=4; out_result holds 1. Then out_ready=1 -> results 1,2,3,4 in order; remaining inputs 5,6 then accepted and delivered. No loss, no duplicates.
5. 10 back-to-back transactions with out_ready=1 -> 10 results on 10 consecutive cycles, in_ready constantly 1, occupancy ≤2.
6. 3 results queued plus 1 in S1, then rst pulsed mid-cycle -> out_valid and occupancy go to 0 immediately, queued data never appears. After release, the first transaction (mode 00, operands 1,2,3) returns 6.

Source files
------------

// File: rtl/math_computer_pipe.sv
// math_computer_pipe
//   Pipelined multi-operand arithmetic unit with a ready/valid input and an
//   output FIFO. Each accepted transaction carries NB_OPERANDS unsigned
//   operands and a mode (00 sum, 01 max, 10 min, 11 saturating sum). The
//   result is computed from the S1 register one edge after acceptance and
//   queued in a circular FIFO, so one transaction per cycle is sustained and
//   downstream back-pressure is absorbed.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     input transaction valid
//   in_ready     block can accept a transaction
//   in_mode      operation select
//   in_operands  operand i at [i*DATASIZE +: DATASIZE]
//   out_valid    result available (FIFO not empty)
//   out_ready    consumer accepts the result
//   out_result   result, RESSIZE bits
//   out_sat      result was clipped (mode 11 only)
//   occupancy    in-flight (S1) plus stored FIFO entries, registered
module math_computer_pipe #(
  parameter int DATASIZE    = 8,
  parameter int NB_OPERANDS = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [1:0]                              in_mode,
  input  logic [NB_OPERANDS*DATASIZE-1:0]         in_operands,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATASIZE+$clog2(NB_OPERANDS)-1:0] out_result,
  output logic                                    out_sat,
  output logic [$clog2(FIFO_DEPTH+2)-1:0]         occupancy
);

  localparam int RESSIZE = DATASIZE + $clog2(NB_OPERANDS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 2);
  localparam logic [RESSIZE-1:0] SAT_MAX = RESSIZE'({DATASIZE{1'b1}});

  // Clip a full-precision sum to the operand range; MSB of the return is the
  // saturation flag.
  function automatic logic [RESSIZE:0] saturate(input logic [RESSIZE-1:0] sum);
    if (sum > SAT_MAX) return {1'b1, SAT_MAX};
    else               return {1'b0, sum};
  endfunction

  logic [NB_OPERANDS*DATASIZE-1:0] ops_p1;
  logic [1:0]                      mode_p1;
  logic                            vld_p1;

  logic [RESSIZE:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [OCC_W-1:0]   occ;

  logic               accept, push, pop, full;
  logic [RESSIZE-1:0] acc, res_p1;
  logic [DATASIZE-1:0] opv, mx, mn;
  logic               sat_p1;
  logic [RESSIZE:0]   rd_data;

  assign in_ready  = !rst && (occ < OCC_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = vld_p1;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign occupancy = occ;

  // ---- stage 0 -> 1: capture operands at acceptance ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ops_p1  <= in_operands;
      mode_p1 <= in_mode;
    end
  end

  // ---- stage 1 -> FIFO: compute result from S1 ----
  always_comb begin
    acc    = '0;
    opv    = '0;
    mx     = ops_p1[0 +: DATASIZE];
    mn     = ops_p1[0 +: DATASIZE];
    res_p1 = '0;
    sat_p1 = 1'b0;
    for (int i = 0; i < NB_OPERANDS; i++) begin
      opv = ops_p1[i*DATASIZE +: DATASIZE];
      acc = acc + RESSIZE'(opv);
      if (opv > mx) mx = opv;
      if (opv < mn) mn = opv;
    end
    case (mode_p1)
      2'b00:   res_p1 = acc;
      2'b01:   res_p1 = RESSIZE'(mx);
      2'b10:   res_p1 = RESSIZE'(mn);
      default: {sat_p1, res_p1} = saturate(acc);
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sat_p1, res_p1};
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap explicitly so non-power-of-2 depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count_next;
      occ   <= OCC_W'(accept) + OCC_W'(count_next);
    end
  end

  // ---- FIFO -> output ----
  // Output is gated by out_valid so reset clears it immediately without
  // resetting the storage array.
  assign rd_data    = mem[rd_ptr];
  assign out_result = out_valid ? rd_data[RESSIZE-1:0] : '0;
  assign out_sat    = out_valid ? rd_data[RESSIZE] : 1'b0;

  // in_ready reserves a slot for S1, so overflow/underflow cannot occur.
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && !out_valid));

endmodule
